// File: rtl/keccak_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the Keccak round sequencer.
package keccak_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_CAPT,
    ST_OUT
  } ctrl_state_t;

  // Keccak-f round count for a given lane width.
  function automatic int unsigned rounds_for(input int unsigned w);
    return int'(12 + 2 * $clog2(w));
  endfunction

  // Bits needed to index n distinct values (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/keccak_round_counter.sv
// Per-round slot counter (CHI_LAT wait slots then one capture slot) and round counter.
module keccak_round_counter
  import keccak_ctrl_pkg::*;
#(
  parameter int unsigned CHI_LAT    = 1,
  parameter int unsigned NUM_ROUNDS = 18,
  parameter int unsigned RW         = 5
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          step,
  output logic          wait_done,
  output logic          last_round,
  output logic [RW-1:0] round
);

  localparam int unsigned     WCW        = idx_width(CHI_LAT + 1);
  localparam logic [WCW-1:0]  SLOT_CAPT  = WCW'(CHI_LAT);
  localparam logic [RW-1:0]   ROUND_LAST = RW'(NUM_ROUNDS - 1);

  logic [WCW-1:0] slot;

  always_ff @(posedge clk) begin
    if (clear) begin
      slot  <= '0;
      round <= '0;
    end else if (step) begin
      if (slot == SLOT_CAPT) begin
        slot <= '0;
        // Saturate on the final round so the index never wraps.
        if (!last_round) round <= round + RW'(1);
      end else begin
        slot <= slot + WCW'(1);
      end
    end
  end

  // True on the last wait slot; never true when CHI_LAT is zero.
  assign wait_done  = ((slot + WCW'(1)) == SLOT_CAPT);
  assign last_round = (round == ROUND_LAST);

endmodule

// File: rtl/keccak_round_ctrl.sv
// Sequencer for the masked Keccak theta-state register: load, round schedule, gated result hand-off.
module keccak_round_ctrl
  import keccak_ctrl_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned b          = 200,
  parameter int unsigned NUM_ROUNDS = rounds_for(W),
  parameter int unsigned CHI_LAT    = 1,
  parameter int unsigned RW         = 5
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  output logic          Busy,
  output logic          LoadSel,
  output logic          EnableLambda,
  output logic          Lastround,
  output logic [RW-1:0] RoundIdx,
  input  logic [b-1:0]  StateIn,
  output logic [b-1:0]  DataOut,
  output logic          DataValid,
  input  logic          DataReady
);

  ctrl_state_t   state;
  logic          in_round;
  logic          cnt_clear;
  logic          wait_done;
  logic          last_round;
  logic [RW-1:0] round;

  assign in_round  = (state == ST_WAIT) || (state == ST_CAPT);
  assign cnt_clear = Reset || !in_round;

  keccak_round_counter #(
    .CHI_LAT   (CHI_LAT),
    .NUM_ROUNDS(NUM_ROUNDS),
    .RW        (RW)
  ) u_counter (
    .clk       (Clock),
    .clear     (cnt_clear),
    .step      (in_round),
    .wait_done (wait_done),
    .last_round(last_round),
    .round     (round)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (Start) state <= ST_LOAD;
        ST_LOAD: state <= (CHI_LAT > 0) ? ST_WAIT : ST_CAPT;
        ST_WAIT: if (wait_done) state <= ST_CAPT;
        ST_CAPT: begin
          if (last_round)       state <= ST_OUT;
          else if (CHI_LAT > 0) state <= ST_WAIT;
          else                  state <= ST_CAPT;
        end
        ST_OUT:  if (DataReady) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    Busy         = (state != ST_IDLE);
    LoadSel      = (state == ST_LOAD);
    EnableLambda = (state == ST_LOAD) || (state == ST_CAPT);
    Lastround    = in_round && last_round;
    RoundIdx     = in_round ? round : '0;
    DataValid    = (state == ST_OUT);
    // Intermediate shares in the state register must never leak out.
    DataOut      = DataValid ? StateIn : '0;
  end

endmodule
